// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_pkg
// Description : Shared DES key-schedule constants, permutation tables, state
//               encoding and helper functions (PC-1, 28-bit rotations).
// Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;

    // Bit r-1 set: round r rotates by one position, otherwise by two.
    localparam logic [15:0] DEF_SHIFT_SCHEDULE = 16'h8103;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Tables use DES numbering: entry value n selects source bit n, bit 1 = MSB.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [2*HALF_W-1:0] res;
        res = '0;
        for (int i = 0; i < 2*HALF_W; i++) begin
            res[6'(2*HALF_W-1-i)] = key[6'(KEY_W - PC1_TBL[i])];
        end
        return res;
    endfunction

    function automatic logic [HALF_W-1:0] rot_l(input logic [HALF_W-1:0] x,
                                                input logic by_one);
        return by_one ? {x[HALF_W-2:0], x[HALF_W-1]}
                      : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
    endfunction

    function automatic logic [HALF_W-1:0] rot_r(input logic [HALF_W-1:0] x,
                                                input logic by_one);
        return by_one ? {x[0], x[HALF_W-1:1]}
                      : {x[1:0], x[HALF_W-1:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
// Module      : des_pc2
// Description : Combinational PC-2 permutation, 56-bit {C,D} -> 48-bit subkey.
// Revision    : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [2*HALF_W-1:0] i_cd,
    output logic [SUBKEY_W-1:0] o_subkey
);

    // PC-2 drops eight of the 56 bits.
    logic w_unused_bits;
    assign w_unused_bits = ^i_cd;

    always_comb begin
        o_subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            o_subkey[6'(SUBKEY_W-1-i)] = i_cd[6'(2*HALF_W - PC2_TBL[i])];
        end
    end

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : des_key_schedule
// Description : Iterative DES key scheduler streaming K1..K16 (encrypt) or
//               K16..K1 (decrypt) over a valid/ready interface.
//               Optional macro DES_KEY_PARITY_EN enables key parity checking.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_pkg::*;
#(
    parameter logic [15:0] SHIFT_SCHEDULE = DEF_SHIFT_SCHEDULE
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid_i,
    output logic                key_ready_o,
    input  logic [KEY_W-1:0]    key_i,
    input  logic                decrypt_i,
    output logic                subkey_valid_o,
    input  logic                subkey_ready_i,
    output logic [SUBKEY_W-1:0] subkey_o,
    output logic [3:0]          subkey_idx_o,
    output logic                subkey_last_o,
    output logic                busy_o,
    output logic                parity_err_o
);

    state_t              r_state, w_state_nxt;
    logic [HALF_W-1:0]   r_c, r_d, w_c_nxt, w_d_nxt;
    logic [3:0]          r_idx, w_idx_nxt;
    logic                r_dir, w_dir_nxt;
    logic                w_parity_ok;
    logic [2*HALF_W-1:0] w_pc1;
    logic [SUBKEY_W-1:0] w_pc2;

    assign w_pc1 = pc1(key_i);

`ifdef DES_KEY_PARITY_EN
    logic [7:0] w_byte_ok;
    logic       r_parity_err;

    for (genvar g = 0; g < 8; g++) begin : g_parity
        assign w_byte_ok[g] = ^key_i[g*8 +: 8];
    end
    assign w_parity_ok = &w_byte_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= key_valid_i & key_ready_o & ~w_parity_ok;
        end
    end
    assign parity_err_o = r_parity_err;
`else
    // Parity bits are not consumed by PC-1 when checking is off.
    logic w_unused_parity;
    assign w_unused_parity = ^key_i;
    assign w_parity_ok     = 1'b1;
    assign parity_err_o    = 1'b0;
`endif

    des_pc2 u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (w_pc2)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_c_nxt        = r_c;
        w_d_nxt        = r_d;
        w_idx_nxt      = r_idx;
        w_dir_nxt      = r_dir;
        key_ready_o    = 1'b0;
        subkey_valid_o = 1'b0;
        busy_o         = 1'b0;
        case (r_state)
            IDLE: begin
                key_ready_o = 1'b1;
                if (key_valid_i && w_parity_ok) begin
                    w_dir_nxt   = decrypt_i;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = GEN;
                    // C0/D0 equals C16/D16, so decrypt starts unrotated.
                    if (decrypt_i) begin
                        w_c_nxt = w_pc1[2*HALF_W-1:HALF_W];
                        w_d_nxt = w_pc1[HALF_W-1:0];
                    end else begin
                        w_c_nxt = rot_l(w_pc1[2*HALF_W-1:HALF_W], SHIFT_SCHEDULE[0]);
                        w_d_nxt = rot_l(w_pc1[HALF_W-1:0], SHIFT_SCHEDULE[0]);
                    end
                end
            end
            GEN: begin
                subkey_valid_o = 1'b1;
                busy_o         = 1'b1;
                if (subkey_ready_i) begin
                    if (r_idx == 4'd15) begin
                        w_state_nxt = IDLE;
                        w_c_nxt     = '0;
                        w_d_nxt     = '0;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                        if (r_dir) begin
                            w_c_nxt = rot_r(r_c, SHIFT_SCHEDULE[4'd15 - r_idx]);
                            w_d_nxt = rot_r(r_d, SHIFT_SCHEDULE[4'd15 - r_idx]);
                        end else begin
                            w_c_nxt = rot_l(r_c, SHIFT_SCHEDULE[r_idx + 4'd1]);
                            w_d_nxt = rot_l(r_d, SHIFT_SCHEDULE[r_idx + 4'd1]);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_idx   <= 4'd0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_idx   <= w_idx_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign subkey_o      = subkey_valid_o ? w_pc2 : '0;
    assign subkey_idx_o  = r_idx;
    assign subkey_last_o = subkey_valid_o && (r_idx == 4'd15);

endmodule
`default_nettype wire
